// File: rtl/bus_cycle_pkg.sv
// Shared types and default timing for the CPU bus cycle controller.
// The optional watchdog is enabled with the BUS_TIMEOUT_EN macro.
package bus_cycle_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_BERR
  } state_e;

  typedef enum logic [2:0] {
    REG_ROM,
    REG_RAM,
    REG_DRAM,
    REG_IO,
    REG_GFX,
    REG_UNMAP
  } region_e;

  localparam int DEF_ROM_WAIT    = 1;
  localparam int DEF_RAM_WAIT    = 1;
  localparam int DEF_IO_WAIT     = 4;
  localparam int DEF_GFX_WAIT    = 2;
  localparam int DEF_UNMAP_WAIT  = 2;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_TIMEOUT_CYC = 200;

  // Decoder selects may overlap; the fixed priority makes the cycle's region unambiguous.
  function automatic region_e decode_region(input logic rom, input logic ram,
                                            input logic dram, input logic io,
                                            input logic gfx);
    if (rom)       return REG_ROM;
    else if (ram)  return REG_RAM;
    else if (dram) return REG_DRAM;
    else if (io)   return REG_IO;
    else if (gfx)  return REG_GFX;
    else           return REG_UNMAP;
  endfunction

endpackage

// File: rtl/bus_wait_counter.sv
// Loadable CNT_W-bit counter: saturating down-counter with zero flag, or
// saturating up-counter when COUNT_UP is set (used as the watchdog).
module bus_wait_counter #(
  parameter int CNT_W    = 8,
  parameter bit COUNT_UP = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset_H,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge Clk) begin
    if (Reset_H) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      if (COUNT_UP) begin
        if (r_count != '1) r_count <= r_count + CNT_W'(1);
      end else begin
        if (r_count != '0) r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/bus_cycle_controller.sv
// Sequences each 68k bus cycle: latches the region, inserts wait states, drives DTACK_L.
// Define BUS_TIMEOUT_EN to add a watchdog that ends hung or unmapped cycles with BERR_L.
module bus_cycle_controller
  import bus_cycle_pkg::*;
#(
  parameter int ROM_WAIT    = DEF_ROM_WAIT,
  parameter int RAM_WAIT    = DEF_RAM_WAIT,
  parameter int IO_WAIT     = DEF_IO_WAIT,
  parameter int GFX_WAIT    = DEF_GFX_WAIT,
  parameter int UNMAP_WAIT  = DEF_UNMAP_WAIT,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic Clk,
  input  logic Reset_H,
  input  logic AS_L,
  input  logic OnChipRomSelect_H,
  input  logic OnChipRamSelect_H,
  input  logic DramSelect_H,
  input  logic IOSelect_H,
  input  logic GfxSelect_H,
  input  logic DramReady_H,
  input  logic TimeoutClear_H,
  output logic DTACK_L,
  output logic BERR_L,
  output logic CycleActive_H,
  output logic TimeoutFlag_H
);

  state_e           r_state, w_next_state;
  region_e          r_region, w_region;
  logic             r_dtack_l, w_dtack_l_nxt;
  logic             w_start, w_in_wait, w_done, w_timeout_hit;
  logic             w_wait_zero;
  logic [CNT_W-1:0] w_unused_wait_cnt;

  function automatic logic [CNT_W-1:0] wait_for(input region_e r);
    case (r)
      REG_ROM: return CNT_W'(ROM_WAIT);
      REG_RAM: return CNT_W'(RAM_WAIT);
      REG_IO:  return CNT_W'(IO_WAIT);
      REG_GFX: return CNT_W'(GFX_WAIT);
      default: return CNT_W'(UNMAP_WAIT);
    endcase
  endfunction

  assign w_region  = decode_region(OnChipRomSelect_H, OnChipRamSelect_H, DramSelect_H,
                                   IOSelect_H, GfxSelect_H);
  assign w_start   = (r_state == ST_IDLE) && !AS_L;
  assign w_in_wait = (r_state == ST_WAIT);

  bus_wait_counter #(.CNT_W(CNT_W), .COUNT_UP(1'b0)) u_wait_cnt (
    .Clk        (Clk),
    .Reset_H    (Reset_H),
    .i_load     (w_start),
    .i_load_val (wait_for(w_region)),
    .i_en       (w_in_wait),
    .o_count    (w_unused_wait_cnt),
    .o_zero     (w_wait_zero)
  );

`ifdef BUS_TIMEOUT_EN
  logic [CNT_W-1:0] w_to_cnt;
  logic             w_unused_to_zero;
  logic             r_berr_l, w_berr_l_nxt;
  logic             r_timeout_flag;

  bus_wait_counter #(.CNT_W(CNT_W), .COUNT_UP(1'b1)) u_timeout_cnt (
    .Clk        (Clk),
    .Reset_H    (Reset_H),
    .i_load     (w_start),
    .i_load_val ('0),
    .i_en       (w_in_wait),
    .o_count    (w_to_cnt),
    .o_zero     (w_unused_to_zero)
  );

  assign w_timeout_hit = w_in_wait && (w_to_cnt == CNT_W'(TIMEOUT_CYC));
  // An unmapped cycle has nobody to answer it, so only the watchdog can end it.
  assign w_done = (r_region == REG_DRAM)  ? DramReady_H :
                  (r_region == REG_UNMAP) ? 1'b0 : w_wait_zero;
  assign w_berr_l_nxt = (w_next_state != ST_BERR);

  always_ff @(posedge Clk) begin
    if (Reset_H) begin
      r_berr_l       <= 1'b1;
      r_timeout_flag <= 1'b0;
    end else begin
      r_berr_l <= w_berr_l_nxt;
      if (w_in_wait && (w_next_state == ST_BERR)) r_timeout_flag <= 1'b1;
      else if (TimeoutClear_H)                    r_timeout_flag <= 1'b0;
    end
  end

  assign BERR_L        = r_berr_l;
  assign TimeoutFlag_H = r_timeout_flag;
`else
  logic w_unused_ok;
  localparam int unused_timeout_cyc = TIMEOUT_CYC;

  assign w_unused_ok   = TimeoutClear_H;
  assign w_timeout_hit = 1'b0;
  assign w_done        = (r_region == REG_DRAM) ? DramReady_H : w_wait_zero;
  assign BERR_L        = 1'b1;
  assign TimeoutFlag_H = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset_H) begin
      r_state   <= ST_IDLE;
      r_region  <= REG_UNMAP;
      r_dtack_l <= 1'b1;
    end else begin
      r_state   <= w_next_state;
      r_dtack_l <= w_dtack_l_nxt;
      if (w_start) r_region <= w_region;
    end
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (!AS_L) w_next_state = ST_WAIT;
      ST_WAIT: begin
        // Abort beats the watchdog, and the watchdog beats a normal completion.
        if (AS_L)               w_next_state = ST_IDLE;
        else if (w_timeout_hit) w_next_state = ST_BERR;
        else if (w_done)        w_next_state = ST_ACK;
      end
      ST_ACK:  if (AS_L) w_next_state = ST_IDLE;
      ST_BERR: if (AS_L) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_dtack_l_nxt = (w_next_state != ST_ACK);
  end

  assign DTACK_L       = r_dtack_l;
  assign CycleActive_H = (r_state != ST_IDLE);

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Self-checking bench for bus_cycle_controller: directed cases plus random cycles
// checked against a per-transaction timing model (follows BUS_TIMEOUT_EN).
module tb_bus_cycle_controller;

  localparam int ROM_WAIT    = 1;
  localparam int RAM_WAIT    = 1;
  localparam int IO_WAIT     = 4;
  localparam int GFX_WAIT    = 2;
  localparam int UNMAP_WAIT  = 2;
  localparam int CNT_W       = 8;
  localparam int TIMEOUT_CYC = 200;
  localparam int NEVER       = 1000000;
`ifdef BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset_H, AS_L, rom_sel, ram_sel, dram_sel, io_sel, gfx_sel;
  logic DramReady_H, TimeoutClear_H;
  logic DTACK_L, BERR_L, CycleActive_H, TimeoutFlag_H;

  int  total = 0;
  int  bad   = 0;
  logic exp_flag = 1'b0;

  always #5 Clk = ~Clk;

  bus_cycle_controller #(
    .ROM_WAIT(ROM_WAIT), .RAM_WAIT(RAM_WAIT), .IO_WAIT(IO_WAIT), .GFX_WAIT(GFX_WAIT),
    .UNMAP_WAIT(UNMAP_WAIT), .CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .Clk               (Clk),
    .Reset_H           (Reset_H),
    .AS_L              (AS_L),
    .OnChipRomSelect_H (rom_sel),
    .OnChipRamSelect_H (ram_sel),
    .DramSelect_H      (dram_sel),
    .IOSelect_H        (io_sel),
    .GfxSelect_H       (gfx_sel),
    .DramReady_H       (DramReady_H),
    .TimeoutClear_H    (TimeoutClear_H),
    .DTACK_L           (DTACK_L),
    .BERR_L            (BERR_L),
    .CycleActive_H     (CycleActive_H),
    .TimeoutFlag_H     (TimeoutFlag_H)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic set_sel(input logic [4:0] s);
    {rom_sel, ram_sel, dram_sel, io_sel, gfx_sel} = s;
  endtask

  task automatic edge_wait();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic dt, input logic be, input logic act);
    check({tag, ".dtack"},  DTACK_L,       dt);
    check({tag, ".berr"},   BERR_L,        be);
    check({tag, ".active"}, CycleActive_H, act);
    check({tag, ".flag"},   TimeoutFlag_H, exp_flag);
  endtask

  task automatic idle_ticks(input int n, input string tag);
    AS_L = 1'b1;
    for (int i = 0; i < n; i++) begin
      edge_wait();
      check_all($sformatf("%s.idle%0d", tag, i), 1'b1, 1'b1, 1'b0);
    end
  endtask

  // One bus cycle: selects s at E0, AS_L low for 'hold' edges (sampled high at E0+hold),
  // DramReady_H sampled high from E0+dram_d on. Outcome is derived from the timing rules.
  task automatic run_txn(input logic [4:0] s, input int hold, input int dram_d,
                         input bit clr_at_to, input string tag);
    int  n, c_edge, t_edge, fin;
    bit  is_dram, is_unmap, aborted, berr, ack;
    is_dram  = 1'b0;
    is_unmap = 1'b0;
    if (s[4])      n = ROM_WAIT;
    else if (s[3]) n = RAM_WAIT;
    else if (s[2]) begin n = 0; is_dram = 1'b1; end
    else if (s[1]) n = IO_WAIT;
    else if (s[0]) n = GFX_WAIT;
    else begin n = UNMAP_WAIT; is_unmap = 1'b1; end
    c_edge  = is_dram ? dram_d : ((is_unmap && TO_EN) ? NEVER : n + 1);
    t_edge  = TO_EN ? TIMEOUT_CYC + 1 : NEVER;
    aborted = hold <= ((c_edge < t_edge) ? c_edge : t_edge);
    berr    = !aborted && (t_edge <= c_edge);
    ack     = !aborted && !berr;
    fin     = berr ? t_edge : c_edge;
    for (int k = 0; k <= hold; k++) begin
      AS_L           = (k >= hold);
      DramReady_H    = (k >= dram_d);
      TimeoutClear_H = clr_at_to && berr && (k == t_edge);
      if (k == 0) set_sel(s);
      else        set_sel(5'($urandom));
      edge_wait();
      if (berr && k == t_edge) exp_flag = 1'b1;
      check_all($sformatf("%s.k%0d", tag, k),
                !(ack && k >= fin && k < hold),
                !(berr && k >= fin && k < hold),
                k < hold);
    end
    TimeoutClear_H = 1'b0;
  endtask

  initial begin
    Reset_H = 1'b1; AS_L = 1'b1; set_sel(5'b0);
    DramReady_H = 1'b0; TimeoutClear_H = 1'b0;
    edge_wait();
    edge_wait();
    check_all("reset", 1'b1, 1'b1, 1'b0);
    Reset_H = 1'b0;
    idle_ticks(2, "post_reset");

    // IO cycle: DTACK_L low at E0+5, released the edge AS_L is sampled high.
    run_txn(5'b00010, 8, NEVER, 1'b0, "io");
    idle_ticks(1, "io");
    // DRAM cycle, DramReady_H driven high after E0+7.
    run_txn(5'b00100, 11, 8, 1'b0, "dram");
    idle_ticks(1, "dram");
    // Aborts: early, and exactly on the edge that would have acknowledged.
    run_txn(5'b00010, 2, NEVER, 1'b0, "abort_early");
    idle_ticks(1, "abort_early");
    run_txn(5'b00010, 5, NEVER, 1'b0, "abort_at_ack");
    idle_ticks(1, "abort_at_ack");
    run_txn(5'b00100, 3, 3, 1'b0, "abort_dram");
    idle_ticks(1, "abort_dram");
    // Priority: ROM wins over IO.
    run_txn(5'b10010, 4, NEVER, 1'b0, "prio");
    idle_ticks(1, "prio");
    run_txn(5'b00001, 5, NEVER, 1'b0, "gfx");
    idle_ticks(1, "gfx");
    // Unmapped: watchdog BERR at E0+201 (clear pulse on that edge loses) or plain ack.
    run_txn(5'b00000, 205, NEVER, 1'b1, "unmap");
    idle_ticks(1, "unmap");
    TimeoutClear_H = 1'b1;
    edge_wait();
    exp_flag = 1'b0;
    check_all("flag_clear", 1'b1, 1'b1, 1'b0);
    TimeoutClear_H = 1'b0;
    idle_ticks(1, "flag_clear");

    for (int t = 0; t < 40; t++) begin
      run_txn(5'($urandom_range(0, 31)), $urandom_range(1, 12), $urandom_range(1, 12),
              1'b0, $sformatf("rnd%0d", t));
      idle_ticks(1, $sformatf("rnd%0d", t));
    end

    // Reset while acknowledging: IO cycle reaches ACK at E0+5, then reset.
    set_sel(5'b00010);
    AS_L = 1'b0;
    for (int k = 0; k <= IO_WAIT + 1; k++) edge_wait();
    check("rst_ack.dtack_before", DTACK_L, 1'b0);
    Reset_H = 1'b1;
    edge_wait();
    exp_flag = 1'b0;
    check_all("rst_ack", 1'b1, 1'b1, 1'b0);
    Reset_H = 1'b0;
    idle_ticks(4, "rst_ack_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
